// File: rtl/fifo_pkg.sv
// Shared async FIFO helpers: pointer Gray coding and the full compare.
// Read-side logic imports the same functions.
package fifo_pkg;

    localparam int ADDR_WIDTH_DEF = 8;
    localparam int FW = 32;

    function automatic logic [FW-1:0] bin2gray(input logic [FW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FW-1:0] gray2bin(input logic [FW-1:0] g);
        logic [FW-1:0] b;
        b = g;
        for (int i = 1; i < FW; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    // Remote Gray pointer with its top two bits inverted: equals our
    // next Gray pointer exactly when we are one full lap ahead.
    function automatic logic [FW-1:0] full_cmp(
        input logic [FW-1:0] g,
        input int            aw
    );
        return g ^ (FW'(3) << (aw - 1));
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter, prefix XOR from the MSB down.
module gray2bin_conv #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[W-1:i];
    end

endmodule

// File: rtl/wr_full_ctrl.sv
// Async FIFO write-side controller: binary/Gray write pointer, RAM
// write strobe, full, almost-full, fill level and sticky overflow.
module wr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int          ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned AF_THRESH  = 2 ** ADDR_WIDTH - 4
) (
    input  logic                  wr_clk,
    input  logic                  wr_rstn,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   syn_rd_ptr,
    input  logic                  ovf_clr,
    output logic [ADDR_WIDTH:0]   wr_ptr,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_mem_en,
    output logic                  wr_full,
    output logic                  wr_almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  wr_overflow
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] bin_q, bin_d;
    logic [PW-1:0] gray_q, gray_d;
    logic [PW-1:0] lvl_q, lvl_d;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] full_ref;
    logic          full_q, full_d;
    logic          af_q, af_d;
    logic          ovf_q, ovf_d;
    logic          wr_inc;

    gray2bin_conv #(
        .W(PW)
    ) u_rd_g2b (
        .gray_i(syn_rd_ptr),
        .bin_o (rd_bin)
    );

    assign full_ref = PW'(full_cmp(FW'(syn_rd_ptr), ADDR_WIDTH));

    always_comb begin
        wr_inc = wr_en & ~full_q;
        bin_d  = bin_q + PW'(wr_inc);
        gray_d = PW'(bin2gray(FW'(bin_d)));
        full_d = (gray_d == full_ref);
        // Lagging read pointer makes this an over-estimate, never under.
        lvl_d  = bin_d - rd_bin;
        af_d   = (FW'(lvl_d) >= AF_THRESH);
        ovf_d  = (wr_en & full_q) | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            bin_q  <= '0;
            gray_q <= '0;
            lvl_q  <= '0;
            full_q <= 1'b0;
            af_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            lvl_q  <= lvl_d;
            full_q <= full_d;
            af_q   <= af_d;
            ovf_q  <= ovf_d;
        end
    end

    assign wr_ptr         = gray_q;
    assign wr_addr        = bin_q[ADDR_WIDTH-1:0];
    assign wr_mem_en      = wr_inc;
    assign wr_full        = full_q;
    assign wr_almost_full = af_q;
    assign wr_level       = lvl_q;
    assign wr_overflow    = ovf_q;

endmodule

// File: tb/tb_wr_full_ctrl.sv
// Bench for wr_full_ctrl: vector table, corner sequences and random
// traffic checked against a write/read count model.
module tb_wr_full_ctrl;

    localparam int AW = 3;
    localparam int DEPTH = 8;
    localparam int AFT = 6;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_en;
    logic [AW:0]   syn_rd_ptr;
    logic          ovf_clr;
    logic [AW:0]   wr_ptr;
    logic [AW-1:0] wr_addr;
    logic          wr_mem_en;
    logic          wr_full;
    logic          wr_almost_full;
    logic [AW:0]   wr_level;
    logic          wr_overflow;

    int checks = 0;
    int errors = 0;

    // Model: total writes accepted and total reads seen, as plain ints.
    int m_w = 0;
    int m_r = 0;
    int m_level = 0;
    bit m_full = 0;
    bit m_ovf = 0;
    bit last_acc = 0;

    always #5 clk = ~clk;

    wr_full_ctrl #(
        .ADDR_WIDTH(AW),
        .AF_THRESH (AFT)
    ) dut (
        .wr_clk        (clk),
        .wr_rstn       (rstn),
        .wr_en         (wr_en),
        .syn_rd_ptr    (syn_rd_ptr),
        .ovf_clr       (ovf_clr),
        .wr_ptr        (wr_ptr),
        .wr_addr       (wr_addr),
        .wr_mem_en     (wr_mem_en),
        .wr_full       (wr_full),
        .wr_almost_full(wr_almost_full),
        .wr_level      (wr_level),
        .wr_overflow   (wr_overflow)
    );

    function automatic int gray(input int v);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk_regs();
        chk("wr_ptr", wr_ptr, gray(m_w % 16));
        chk("wr_addr", wr_addr, m_w % DEPTH);
        chk("wr_full", wr_full, m_full);
        chk("wr_af", wr_almost_full, m_level >= AFT);
        chk("wr_level", wr_level, m_level);
        chk("wr_ovf", wr_overflow, m_ovf);
    endtask

    task automatic tick(input bit we, input bit clr, input int radv);
        logic [AW:0] prev;
        bit acc;
        @(negedge clk);
        wr_en = we;
        ovf_clr = clr;
        m_r += radv;
        syn_rd_ptr = (AW+1)'(gray(m_r % 16));
        #1;
        chk("wr_mem_en", wr_mem_en, we && !m_full);
        prev = wr_ptr;
        @(posedge clk);
        acc = we && !m_full;
        m_ovf = (we && m_full) || (m_ovf && !clr);
        if (acc) m_w++;
        m_level = m_w - m_r;
        m_full = (m_level == DEPTH);
        last_acc = acc;
        #1;
        chk_regs();
        chk("ptr_onebit", $countones(prev ^ wr_ptr), acc ? 1 : 0);
        chk("level_le_depth", int'(wr_level) <= DEPTH, 1);
    endtask

    typedef struct {
        bit          we;
        bit          clr;
        int          radv;
        logic [3:0]  e_ptr;
        bit          e_mem_en;
        bit          e_af;
        bit          e_full;
        int          e_lvl;
        bit          e_ovf;
    } vec_t;

    vec_t vt[$];

    initial begin
        rstn = 1'b0;
        wr_en = 1'b0;
        ovf_clr = 1'b0;
        syn_rd_ptr = '0;

        #12;
        chk("rst_ptr", wr_ptr, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_full", wr_full, 0);
        chk("rst_af", wr_almost_full, 0);
        chk("rst_level", wr_level, 0);
        chk("rst_ovf", wr_overflow, 0);
        wr_en = 1'b1;
        #1;
        chk("rst_mem_en", wr_mem_en, 1);
        wr_en = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        // Fill, overflow/clear and drain vectors with literal expectations.
        vt.push_back('{1, 0, 0, 4'h1, 1, 0, 0, 1, 0});
        vt.push_back('{1, 0, 0, 4'h3, 1, 0, 0, 2, 0});
        vt.push_back('{1, 0, 0, 4'h2, 1, 0, 0, 3, 0});
        vt.push_back('{1, 0, 0, 4'h6, 1, 0, 0, 4, 0});
        vt.push_back('{1, 0, 0, 4'h7, 1, 0, 0, 5, 0});
        vt.push_back('{1, 0, 0, 4'h5, 1, 1, 0, 6, 0});
        vt.push_back('{1, 0, 0, 4'h4, 1, 1, 0, 7, 0});
        vt.push_back('{1, 0, 0, 4'hC, 1, 1, 1, 8, 0});
        vt.push_back('{1, 0, 0, 4'hC, 0, 1, 1, 8, 1});
        vt.push_back('{1, 0, 0, 4'hC, 0, 1, 1, 8, 1});
        vt.push_back('{0, 1, 0, 4'hC, 0, 1, 1, 8, 0});
        vt.push_back('{1, 1, 0, 4'hC, 0, 1, 1, 8, 1});
        vt.push_back('{0, 0, 2, 4'hC, 0, 1, 0, 6, 1});
        vt.push_back('{0, 0, 1, 4'hC, 0, 0, 0, 5, 1});

        foreach (vt[i]) begin
            @(negedge clk);
            wr_en = vt[i].we;
            ovf_clr = vt[i].clr;
            m_r += vt[i].radv;
            syn_rd_ptr = (AW+1)'(gray(m_r % 16));
            #1;
            chk("vec_mem_en", wr_mem_en, vt[i].e_mem_en);
            @(posedge clk);
            if (vt[i].we && !m_full) m_w++;
            m_ovf = (vt[i].we && m_full) || (m_ovf && !vt[i].clr);
            m_level = m_w - m_r;
            m_full = (m_level == DEPTH);
            #1;
            chk("vec_ptr", wr_ptr, vt[i].e_ptr);
            chk("vec_addr", wr_addr, m_w % DEPTH);
            chk("vec_af", wr_almost_full, vt[i].e_af);
            chk("vec_full", wr_full, vt[i].e_full);
            chk("vec_level", wr_level, vt[i].e_lvl);
            chk("vec_ovf", wr_overflow, vt[i].e_ovf);
        end

        tick(0, 1, 0);
        // Refill to full, then write while the read pointer advances.
        repeat (3) tick(1, 0, 0);
        chk("refill_full", wr_full, 1);
        tick(1, 0, 1);
        chk("simul_no_acc", last_acc, 0);
        chk("simul_not_full", wr_full, 0);
        tick(1, 1, 0);
        chk("simul_acc_next", last_acc, 1);

        // Wrap-around: writes interleaved with matching reads.
        for (int i = 0; i < 20; i++) begin
            tick(1, 0, (m_w > m_r) ? 1 : 0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            bit we;
            bit clr;
            int radv;
            we = ($urandom_range(0, 99) < 65);
            clr = ($urandom_range(0, 7) == 0);
            radv = 0;
            if (m_w > m_r && $urandom_range(0, 99) < 45) radv = 1;
            tick(we, clr, radv);
        end

        // Asynchronous reset in the middle of a burst.
        tick(1, 0, 0);
        tick(1, 0, 0);
        @(negedge clk);
        wr_en = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        m_w = 0;
        m_r = 0;
        m_level = 0;
        m_full = 0;
        m_ovf = 0;
        chk_regs();
        chk("midrst_mem_en", wr_mem_en, 1);
        syn_rd_ptr = '0;
        wr_en = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("post_rst_addr", wr_addr, 0);
        tick(1, 0, 0);
        tick(1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wr_full_ctrl.md
Name: wr_full_ctrl

Overview:
Write-side pointer and status controller of the async FIFO. It is the write-domain counterpart that feeds the read-side empty logic. It owns the binary write pointer and its Gray copy, which is synchronized into the read domain. It generates the RAM write address and write enable, and raises full, almost-full, fill level and a sticky overflow flag. Its read-pointer input is already synchronized into wr_clk by an external 2-FF synchronizer.

Parameters:
- ADDR_WIDTH, 8, RAM address width; depth = 2^ADDR_WIDTH; must be >= 2.
- AF_THRESH, 2^ADDR_WIDTH-4, almost_full asserts when the fill level is >= this value; legal range 1..2^ADDR_WIDTH.

Ports:
- wr_clk  in  1  write-domain clock.
- wr_rstn  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- syn_rd_ptr  in  ADDR_WIDTH+1  Gray read pointer, already synchronized to wr_clk.
- ovf_clr  in  1  clears the sticky overflow flag.
- wr_ptr  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
- wr_addr  out  ADDR_WIDTH  RAM write address = low bits of the binary pointer.
- wr_mem_en  out  1  RAM write strobe = wr_en & ~wr_full (combinational).
- wr_full  out  1  registered full flag.
- wr_almost_full  out  1  registered almost-full flag.
- wr_level  out  ADDR_WIDTH+1  registered fill level, 0..2^ADDR_WIDTH.
- wr_overflow  out  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (async, wr_rstn=0): binary pointer, wr_ptr, wr_full, wr_almost_full, wr_level and wr_overflow all 0. Therefore wr_addr=0 and wr_mem_en=wr_en.
- Write acceptance: wr_inc = wr_en & ~wr_full. bin_next = bin + wr_inc, modulo 2^(ADDR_WIDTH+1); the wrap is natural with no special handling.
- Gray encoding: gray_next = (bin_next>>1) ^ bin_next. The binary pointer and wr_ptr are both registered from their _next values on the same edge, so wr_ptr is glitch-free with exactly one bit change per accepted write.
- Full: wr_full <= (gray_next == {~syn_rd_ptr[AW:AW-1], syn_rd_ptr[AW-2:0]}). The flag is computed from the next pointer, so it asserts in the same cycle as the write that fills the last slot, with no overrun window.
- Level: rd_bin = Gray-to-binary of syn_rd_ptr (combinational XOR prefix). wr_level <= bin_next - rd_bin, width ADDR_WIDTH+1, modulo arithmetic.
  - The level is pessimistic: it never under-reports, because the read pointer lags by the synchronizer delay.
- Almost-full: wr_almost_full <= (bin_next - rd_bin) >= AF_THRESH. At full, wr_level = 2^ADDR_WIDTH and wr_almost_full = 1.
- Full deassertion: wr_full and wr_level update one cycle after syn_rd_ptr changes.
- Overflow: on a clock edge with wr_en=1 and wr_full=1, wr_overflow is set; the pointer does not move and wr_mem_en=0.
  - ovf_clr=1 clears the flag.
  - If set and clear happen in the same cycle, set wins.
- Simultaneous write and read-pointer advance while full: no write is accepted that cycle. The next cycle wr_full=0 (assuming no new write), and a write is accepted the cycle after that.
- Reset mid-operation: all state clears immediately. It is the system's responsibility to reset the read side together with the write side.

Decomposition:
- Shared package fifo_pkg holds:
  - the ADDR_WIDTH default;
  - a bin2gray function;
  - a gray2bin function;
  - the full-compare helper (inverted top two bits).
  The read-side logic reuses these functions.
- One natural sub-module is gray2bin_conv (combinational, parameterized width), shared with any read-side level logic.

Test Plan:
All scenarios use ADDR_WIDTH=3 and AF_THRESH=6, with syn_rd_ptr driven by the bench.
- Reset check: assert wr_rstn=0 mid-burst -> all outputs 0 immediately, and wr_addr=0 after release.
- Fill from empty: hold wr_en for 8 cycles with syn_rd_ptr=0 -> wr_addr steps 0..7; wr_ptr Gray sequence is 0,1,3,2,6,7,5,4,C.
  - wr_almost_full is 1 after the 6th write.
  - wr_full is 1 after the 8th write, with wr_level=8.
- Overflow: keep wr_en=1 while full for 2 cycles -> wr_mem_en=0, pointer holds at bin 8, wr_overflow=1.
  - A pulse on ovf_clr clears it.
  - With ovf_clr and a write-while-full in the same cycle, the flag stays 1.
- Read drain: while full, set syn_rd_ptr to Gray(2)=3 -> one cycle later wr_full=0, wr_level=6, wr_almost_full=1.
  - Set syn_rd_ptr to Gray(3)=2 -> one cycle later wr_level=5, wr_almost_full=0.
- Wrap-around: run 20 writes interleaved with matching read-pointer updates -> the binary pointer wraps 15->0, wr_ptr changes exactly one bit per accepted write, and wr_level never exceeds 8.
